// File: rtl/demux8_ctrl.sv
// demux8_ctrl: routes one input word to one of eight channels.
// In addressed mode the destination is i_dest. In round-robin mode it is the
// first enabled channel at or after the rotating pointer.
// A word is held on its channel until that channel acknowledges it.
// The word is dropped, with an err pulse and a saturating drop count, if it is
// addressed to a masked channel or if TIMEOUT SEND cycles pass without an ack.
module demux8_ctrl #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic [2:0]       i_dest,
  input  logic             i_mode,
  input  logic [7:0]       i_mask,
  input  logic             i_valid,
  output logic             i_ready,
  output logic [2:0]       sel,
  output logic [WIDTH-1:0] y_data,
  output logic [7:0]       y_valid,
  input  logic [7:0]       y_ack,
  output logic             err,
  output logic [7:0]       drop_cnt
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [2:0]       rr_q, rr_d;
  logic [7:0]       timer_q, timer_d;
  logic [2:0]       sel_q, sel_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;
  logic [7:0]       drop_q, drop_d;

  logic       accept;
  logic       drop_inc;
  logic [2:0] rr_dest;
  logic [2:0] dest_w;

  // Round-robin pick: scan offsets from high to low so the smallest
  // enabled offset from rr_q is the one that survives.
  always_comb begin
    rr_dest = rr_q;
    for (int k = 7; k >= 0; k--) begin
      if (i_mask[rr_q + 3'(k)]) rr_dest = rr_q + 3'(k);
    end
  end

  // Round-robin with an empty mask has nowhere to go, so it stalls the input.
  assign i_ready = ~rst & (state_q == IDLE) & ~(i_mode & (i_mask == 8'h00));
  assign accept  = i_valid & i_ready;
  assign dest_w  = i_mode ? rr_dest : i_dest;

  // Next-state logic: accept, drop, deliver or time out.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    timer_d  = timer_q;
    sel_d    = sel_q;
    data_d   = data_q;
    err_d    = 1'b0;
    drop_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!i_mode && !i_mask[i_dest]) begin
            err_d    = 1'b1;
            drop_inc = 1'b1;
          end else begin
            state_d = SEND;
            sel_d   = dest_w;
            data_d  = i_data;
            timer_d = 8'd0;
          end
        end
      end
      SEND: begin
        // An ack in the expiry cycle wins over the timeout.
        if (y_ack[sel_q]) begin
          state_d = IDLE;
          rr_d    = sel_q + 3'd1;
        end else if (timer_q == 8'(TIMEOUT - 1)) begin
          state_d  = IDLE;
          rr_d     = sel_q + 3'd1;
          err_d    = 1'b1;
          drop_inc = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    drop_d = (drop_inc && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end

  // State registers with synchronous reset; a reset during SEND discards the word silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 3'd0;
      timer_q <= 8'd0;
      sel_q   <= 3'd0;
      data_q  <= '0;
      err_q   <= 1'b0;
      drop_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      timer_q <= timer_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  assign sel      = sel_q;
  assign y_data   = data_q;
  assign y_valid  = (state_q == SEND) ? (8'b1 << sel_q) : 8'h00;
  assign err      = err_q;
  assign drop_cnt = drop_q;

endmodule

// File: doc/demux8_ctrl.md
DEMUX8_CTRL -- requirements
Module: demux8_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, data word width in bits.
REQ-002 Parameter: TIMEOUT, default 16, maximum SEND cycles without acknowledge; legal range 2..255.
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 i_data  input  WIDTH  input word.
REQ-006 i_dest  input  3  destination channel; used in addressed mode.
REQ-007 i_mode  input  1  0 = addressed, 1 = round-robin.
REQ-008 i_mask  input  8  channel enable mask; bit k enables channel k.
REQ-009 i_valid  input  1  input word valid.
REQ-010 i_ready  output  1  controller can accept a word.
REQ-011 sel  output  3  demux select; sel[0]=s0 is the LSB.
REQ-012 y_data  output  WIDTH  routed word; shared by all channels.
REQ-013 y_valid  output  8  one-hot channel valid.
REQ-014 y_ack  input  8  per-channel acknowledge.
REQ-015 err  output  1  one-cycle pulse when a word is dropped.
REQ-016 drop_cnt  output  8  count of dropped words; saturates at 255.

Function
REQ-017 FSM states: IDLE and SEND.
REQ-018 i_ready SHALL be 1 only in IDLE, and SHALL be 0 in IDLE when i_mode=1 and i_mask=8'h00.
REQ-019 Accept = i_valid & i_ready at a rising edge; i_data, i_mode and i_mask are sampled only at accept.
REQ-020 Addressed-mode destination SHALL be i_dest.
REQ-021 Round-robin destination SHALL be the first enabled channel at or after rr_ptr, searching upward and wrapping 7 -> 0.
REQ-022 Addressed accept with i_mask[i_dest]=0 SHALL drop the word: err=1 next cycle, drop_cnt+1, state stays IDLE, rr_ptr unchanged.
REQ-023 Otherwise accept SHALL register data, dest and sel=dest, and move to SEND; y_valid[dest] rises in the cycle after accept (latency 1).
REQ-024 In SEND:
  - y_valid = one-hot(dest);
  - y_data = registered word;
  - sel holds dest;
  - y_data, sel and y_valid are stable until the transfer completes.
REQ-025 Transfer completes at the first edge in SEND with y_ack[dest]=1: next state IDLE, y_valid=0, rr_ptr=(dest+1) mod 8.
REQ-026 y_ack bits other than dest SHALL be ignored.
REQ-027 Timer SHALL clear on entering SEND and increment each SEND cycle without acknowledge.
REQ-028 If y_ack[dest] is still 0 in the TIMEOUT-th SEND cycle:
  - the word is dropped;
  - err=1 for one cycle;
  - drop_cnt+1;
  - next state IDLE;
  - rr_ptr=(dest+1) mod 8.
REQ-029 Acknowledge in the same cycle as timeout expiry SHALL count as delivery: no drop, no err.
REQ-030 drop_cnt SHALL saturate at 8'hFF and not wrap.
REQ-031 sel and y_data SHALL retain their last values in IDLE; y_valid SHALL be 8'h00 in IDLE.
REQ-032 Peak throughput SHALL be one word per 2 cycles: accept, then SEND with immediate acknowledge.
REQ-033 Changes to i_mask or i_mode during SEND SHALL not affect the word in flight.

Reset
REQ-034 While rst=1 at a rising edge, all of the following SHALL take their reset values at that edge:
  - state=IDLE, rr_ptr=0, timer=0;
  - sel=3'b000, y_data=0, y_valid=8'h00;
  - err=0, drop_cnt=8'h00.
REQ-035 i_ready SHALL be 0 while rst=1 and follow REQ-018 from the first cycle after rst deasserts.
REQ-036 rst asserted during SEND SHALL abandon the word with no err pulse and no drop_cnt increment.

Verification
REQ-037 Addressed delivery:
  - stimulus: mask=FF, mode=0, i_dest=5, i_data=8'hA5, accept, y_ack[5]=1 one cycle later;
  - response: y_valid=8'b0010_0000, sel=5, y_data=A5 for one cycle, then IDLE with i_ready=1.
REQ-038 Round-robin skip:
  - stimulus: mode=1, mask=8'b1000_0101, rr_ptr=0, four words each acknowledged immediately;
  - response: destinations 0, 2, 7, 0.
REQ-039 Timeout:
  - stimulus: TIMEOUT=16, dest=3, y_ack held 0;
  - response: y_valid[3] high for 16 cycles, err pulse, drop_cnt=1, rr_ptr=4.
REQ-040 Masked addressed drop:
  - stimulus: mask=8'hFE, mode=0, i_dest=0, accept;
  - response: no y_valid activity, err pulse, drop_cnt increments; the next word is accepted.
REQ-041 Stalls and saturation:
  - stimulus 1: mode=1, mask=00;
  - response 1: i_ready=0 and nothing is accepted.
  - stimulus 2: 260 forced drops;
  - response 2: drop_cnt=FF.
REQ-042 Reset mid-SEND:
  - stimulus: assert rst while y_valid[6]=1;
  - response: next cycle y_valid=00, sel=0, drop_cnt=0, err=0.
